// File: rtl/ssd_pkg.sv
// Shared constants for the multiplexed seven-segment scan controller:
// register field positions, reset values and the hex-to-segment table.
package ssd_pkg;

  // Digit register fields
  localparam int VAL_LSB   = 0;
  localparam int VAL_W     = 4;
  localparam int DP_BIT    = 4;
  localparam int BLANK_BIT = 5;

  // Control register fields (brightness occupies [BRIGHT_W-1:0])
  localparam int GBLANK_BIT = 7;

  localparam logic [7:0] DIGIT_RST = 8'h20;
  localparam logic [6:0] SEG_OFF   = 7'h00;

  // Active-high {g,f,e,d,c,b,a}; entry 0 is the least significant slice.
  localparam logic [15:0][6:0] HEX_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/ssd_hex_decoder.sv
// Combinational 4-bit hex value to active-high seven-segment pattern {g..a}.
module ssd_hex_decoder
  import ssd_pkg::*;
(
  input  logic [3:0] value,
  output logic [6:0] seg
);

  assign seg = HEX_TABLE[value];

endmodule

// File: rtl/ssd_scan_ctrl.sv
// Multiplexed seven-segment scan controller with per-digit registers, PWM
// brightness and a dead cycle per slot. Define SSD_LZB_EN for leading-zero blanking.
module ssd_scan_ctrl
  import ssd_pkg::*;
#(
  parameter int N_DIGITS         = 4,
  parameter int SCAN_DIV         = 100000,
  parameter int BRIGHT_W         = 4,
  parameter bit ANODE_ACTIVE_LOW = 1'b1,
  parameter bit SEG_ACTIVE_LOW   = 1'b1,
  localparam int ADDR_W          = $clog2(N_DIGITS + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [7:0]          wr_data,
  output logic [N_DIGITS-1:0] ssd_anode,
  output logic [6:0]          ssd_seg,
  output logic                ssd_dp
);

  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int PRE_W = $clog2(SCAN_DIV);

  localparam logic [ADDR_W-1:0]   CTRL_ADDR  = ADDR_W'(N_DIGITS);
  localparam logic [PRE_W-1:0]    PRE_LAST   = PRE_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]    IDX_LAST   = IDX_W'(N_DIGITS - 1);
  localparam logic [N_DIGITS-1:0] ANODE_XOR  = {N_DIGITS{ANODE_ACTIVE_LOW}};
  localparam logic [6:0]          SEG_XOR    = {7{SEG_ACTIVE_LOW}};

  logic [7:0]          digit_q [N_DIGITS];
  logic [BRIGHT_W-1:0] bright_q;
  logic                gblank_q;
  logic [PRE_W-1:0]    presc_q;
  logic [IDX_W-1:0]    idx_q;
  logic [BRIGHT_W-1:0] pwm_q;

  logic [7:0]          cur_digit;
  logic [6:0]          dec_seg;
  logic                lzb_blank;
  logic                digit_blank;
  logic                anode_on;
  logic [N_DIGITS-1:0] anode_hi;
  logic [6:0]          seg_hi;
  logic                dp_hi;

  // Register file: address decode by loop keeps index widths exact.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_DIGITS; i++) digit_q[i] <= DIGIT_RST;
      bright_q <= '1;
      gblank_q <= 1'b0;
    end else if (wr_en) begin
      for (int i = 0; i < N_DIGITS; i++) begin
        if (wr_addr == ADDR_W'(i)) digit_q[i] <= wr_data;
      end
      if (wr_addr == CTRL_ADDR) begin
        bright_q <= wr_data[BRIGHT_W-1:0];
        gblank_q <= wr_data[GBLANK_BIT];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q <= '0;
      idx_q   <= '0;
      pwm_q   <= '0;
    end else begin
      pwm_q <= pwm_q + 1'b1;
      if (presc_q == PRE_LAST) begin
        presc_q <= '0;
        idx_q   <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end else begin
        presc_q <= presc_q + 1'b1;
      end
    end
  end

  always_comb begin
    cur_digit = digit_q[0];
    for (int i = 0; i < N_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) cur_digit = digit_q[i];
    end
  end

`ifdef SSD_LZB_EN
  // zero_above[i]: digit i and every higher digit hold value 0 with dp clear.
  logic [N_DIGITS:0] zero_above;

  always_comb begin
    zero_above           = '0;
    zero_above[N_DIGITS] = 1'b1;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      zero_above[i] = zero_above[i+1] && (digit_q[i][DP_BIT:VAL_LSB] == 5'd0);
    end
    lzb_blank = 1'b0;
    for (int i = 1; i < N_DIGITS; i++) begin
      if (idx_q == IDX_W'(i) && zero_above[i]) lzb_blank = 1'b1;
    end
  end
`else
  assign lzb_blank = 1'b0;
`endif

  ssd_hex_decoder u_dec (
    .value (cur_digit[VAL_LSB +: VAL_W]),
    .seg   (dec_seg)
  );

  assign digit_blank = cur_digit[BLANK_BIT] | gblank_q | lzb_blank;
  assign anode_on    = !digit_blank && (presc_q != PRE_LAST) && (pwm_q <= bright_q);
  assign seg_hi      = digit_blank ? SEG_OFF : dec_seg;
  assign dp_hi       = !digit_blank && cur_digit[DP_BIT];

  always_comb begin
    anode_hi = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (anode_on && idx_q == IDX_W'(i)) anode_hi[i] = 1'b1;
    end
  end

  // Pins are registered in active-high form then flipped to board polarity.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ssd_anode <= ANODE_XOR;
      ssd_seg   <= SEG_OFF ^ SEG_XOR;
      ssd_dp    <= SEG_ACTIVE_LOW;
    end else begin
      ssd_anode <= anode_hi ^ ANODE_XOR;
      ssd_seg   <= seg_hi ^ SEG_XOR;
      ssd_dp    <= dp_hi ^ SEG_ACTIVE_LOW;
    end
  end

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Directed bench for ssd_scan_ctrl (4 digits, 8-cycle slots) with a cycle model
// feeding an expected queue, plus directed pin checks.
module tb_ssd_scan_ctrl;

  localparam int N   = 4;
  localparam int DIV = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_en = 1'b0;
  logic [2:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic [3:0] ssd_anode;
  logic [6:0] ssd_seg;
  logic       ssd_dp;

  int n_assert = 0;
  int n_fail   = 0;

  logic [11:0] exp_q[$];

  int         m_presc, m_idx, m_pwm;
  logic [7:0] m_dig [N];
  logic [3:0] m_bright;
  logic       m_gblank;

  logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  ssd_scan_ctrl #(
    .N_DIGITS(N), .SCAN_DIV(DIV), .BRIGHT_W(4),
    .ANODE_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .ssd_anode(ssd_anode), .ssd_seg(ssd_seg), .ssd_dp(ssd_dp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed anode/seg/dp=%h required %h", tag, got, exp);
    end
  endtask

  task automatic check_int(input string tag, input int got, input int exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d required %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_presc = 0; m_idx = 0; m_pwm = 0;
    for (int i = 0; i < N; i++) m_dig[i] = 8'h20;
    m_bright = 4'hF;
    m_gblank = 1'b0;
  endtask

  function automatic logic [11:0] model_out();
    logic       blank;
    logic [3:0] an;
    logic [6:0] sg;
    logic       dp;
    logic [7:0] d;
    d     = m_dig[m_idx];
    blank = d[5] | m_gblank;
`ifdef SSD_LZB_EN
    if (m_idx > 0) begin
      logic lz;
      lz = 1'b1;
      for (int j = m_idx; j < N; j++) if (m_dig[j][4:0] != 5'd0) lz = 1'b0;
      if (lz) blank = 1'b1;
    end
`endif
    an = 4'hF;
    if (!blank && m_presc != DIV - 1 && m_pwm <= int'(m_bright)) an[m_idx] = 1'b0;
    sg = blank ? 7'h7F : ~hex_tab[d[3:0]];
    dp = blank ? 1'b1 : ~d[4];
    return {an, sg, dp};
  endfunction

  // One clock: drive inputs, predict the next registered output, advance model.
  task automatic step(input logic we, input logic [2:0] a, input logic [7:0] d, input string tag);
    wr_en = we; wr_addr = a; wr_data = d;
    exp_q.push_back(model_out());
    if (we) begin
      if (a < 3'(N)) m_dig[a] = d;
      else if (a == 3'(N)) begin m_bright = d[3:0]; m_gblank = d[7]; end
    end
    m_pwm = (m_pwm + 1) % 16;
    if (m_presc == DIV - 1) begin m_presc = 0; m_idx = (m_idx + 1) % N; end
    else m_presc++;
    @(posedge clk); #1;
    wr_en = 1'b0;
    check(tag, {ssd_anode, ssd_seg, ssd_dp}, exp_q.pop_front());
  endtask

  initial begin
    int c [4];
    int act;
    int k;

    model_reset();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("reset_out", {ssd_anode, ssd_seg, ssd_dp}, {4'hF, 7'h7F, 1'b1});
    repeat (10) step(1'b0, 3'd0, 8'h00, "idle_blank");

    for (int i = 0; i < N; i++) step(1'b1, 3'(i), 8'(i + 1), "wr_digit");
    repeat (40) step(1'b0, 3'd0, 8'h00, "scan_full");

    c = '{0, 0, 0, 0};
    for (int i = 0; i < 32; i++) begin
      step(1'b0, 3'd0, 8'h00, "scan_window");
      case (ssd_anode)
        4'hE: c[0]++;
        4'hD: c[1]++;
        4'hB: c[2]++;
        4'h7: c[3]++;
        default: ;
      endcase
    end
    for (int i = 0; i < N; i++) check_int($sformatf("active_cycles_d%0d", i), c[i], 7);

    step(1'b1, 3'd4, 8'h00, "wr_bright0");
    act = 0;
    for (int i = 0; i < 64; i++) begin
      step(1'b0, 3'd0, 8'h00, "pwm_min");
      if (ssd_anode != 4'hF) act++;
    end
    check_int("pwm_min_active", act, 4);

    step(1'b1, 3'd5, 8'h08, "wr_bad_addr");
    step(1'b1, 3'd4, 8'h80, "wr_gblank");
    act = 0;
    for (int i = 0; i < 32; i++) begin
      step(1'b0, 3'd0, 8'h00, "gblank");
      if (ssd_anode != 4'hF) act++;
    end
    check_int("gblank_active", act, 0);
    step(1'b1, 3'd4, 8'h0F, "wr_bright_full");
    repeat (32) step(1'b0, 3'd0, 8'h00, "restored");

    k = 0;
    while (!(m_idx == 2 && m_presc == 3) && k < 64) begin
      step(1'b0, 3'd0, 8'h00, "seek_slot2");
      k++;
    end
    check_int("seek_slot2_bound", int'(k < 64), 1);
    check_int("slot2_anode", int'(ssd_anode), 32'hB);
    #2 reset = 1'b1;
    #1 check("async_reset_out", {ssd_anode, ssd_seg, ssd_dp}, {4'hF, 7'h7F, 1'b1});
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    exp_q.delete();

    step(1'b1, 3'd0, 8'h00, "wr_lzb");
    step(1'b1, 3'd1, 8'h05, "wr_lzb");
    step(1'b1, 3'd2, 8'h00, "wr_lzb");
    step(1'b1, 3'd3, 8'h00, "wr_lzb");
    step(1'b0, 3'd0, 8'h00, "restart_idx0");
    check_int("restart_anode", int'(ssd_anode), 32'hE);
    repeat (64) step(1'b0, 3'd0, 8'h00, "lzb_scan");

    step(1'b1, 3'd3, 8'h10, "wr_dp3");
    repeat (32) step(1'b0, 3'd0, 8'h00, "lzb_dp");
    step(1'b1, 3'd1, 8'h25, "wr_blank1");
    repeat (32) step(1'b0, 3'd0, 8'h00, "digit_blank");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
